// File: rtl/bitcell_pkg.sv
// Shared definitions for the bitcell array controller: FSM state encoding and default geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package bitcell_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bitcell_array_ctrl_if.sv
// Request/response bundle between the request FSM (master) and the array controller (slave).
// Latency: n/a (wires only).
// Backpressure: busy flags an in-flight access; requests seen while busy are dropped, not held.
//   master drives: valid, rw, addr, wdata
//   slave drives : wl, we, rdata, done, busy, drop
interface bitcell_array_ctrl_if
    import bitcell_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                   valid;
    logic                   rw;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      wdata;
    logic [2**ADDR_W-1:0]   wl;
    logic                   we;
    logic [DATA_W-1:0]      rdata;
    logic                   done;
    logic                   busy;
    logic                   drop;

    modport master (
        output valid, rw, addr, wdata,
        input  wl, we, rdata, done, busy, drop
    );

    modport slave (
        input  valid, rw, addr, wdata,
        output wl, we, rdata, done, busy, drop
    );

endinterface

// File: rtl/bitcell_row.sv
// One word of DATA_W bitcells; stores d when its word line and write enable are both high.
// Latency: write commits on the rising clk edge at the end of the enabled cycle; q is always visible.
// Backpressure: none.
//   clk in, wl in (word line), we in (write enable), d in [DATA_W], q out [DATA_W]
module bitcell_row #(
    parameter int DATA_W = bitcell_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              wl,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // The cross-coupled NAND pair is modelled as clocked storage so the write lands
    // exactly on the edge that leaves ACCESS. Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wl && we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// Executes one read or write per accepted request on a 2**ADDR_W x DATA_W bitcell array.
// Latency: 3 cycles from accepting edge to done; a new request may be accepted in the DONE cycle.
// Backpressure: busy in DECODE/ACCESS; a valid seen while busy is discarded and drop pulses next cycle.
//   clk, rst (sync, active-high); bus: slave side of bitcell_array_ctrl_if
module bitcell_array_ctrl
    import bitcell_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    bitcell_array_ctrl_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                rw_q;
    logic                rw_nxt;
    logic [DEPTH-1:0]    wl_q;
    logic [DEPTH-1:0]    wl_nxt;
    logic                we_q;
    logic                we_nxt;
    logic [DATA_W-1:0]   rdata_q;
    logic                drop_q;
    logic                busy;
    logic                row_we;
    logic [DATA_W-1:0]   row_q [DEPTH];

    assign busy = (state == DECODE) || (state == ACCESS);

    // Next-state and next-output logic. wl/we are computed from the next state and
    // registered, so the row drivers see clean flop outputs with no path from inputs.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rw_nxt    = rw_q;
        wl_nxt    = '0;
        we_nxt    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (bus.valid) begin
                    state_nxt = DECODE;
                    addr_nxt  = bus.addr;
                    wdata_nxt = bus.wdata;
                    rw_nxt    = bus.rw;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DECODE:  state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt == DECODE) || (state_nxt == ACCESS)) begin
            wl_nxt[addr_nxt] = 1'b1;
        end
        we_nxt = (state_nxt == ACCESS) && rw_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            wl_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rw_q    <= rw_nxt;
            wl_q    <= wl_nxt;
            we_q    <= we_nxt;
            drop_q  <= bus.valid && busy;
            // Read sense happens on the same edge a write would commit.
            if ((state == ACCESS) && !rw_q) begin
                rdata_q <= row_q[addr_q];
            end
        end
    end

    // Reset must also suppress a commit that coincides with it, so the
    // row-facing enable is qualified with rst.
    assign row_we = we_q && !rst;

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        bitcell_row #(
            .DATA_W (DATA_W)
        ) u_row (
            .clk (clk),
            .wl  (wl_q[i]),
            .we  (row_we),
            .d   (wdata_q),
            .q   (row_q[i])
        );
    end

    assign bus.wl    = wl_q;
    assign bus.we    = we_q;
    assign bus.rdata = rdata_q;
    assign bus.done  = (state == DONE);
    assign bus.busy  = busy;
    assign bus.drop  = drop_q;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Self-checking bench for bitcell_array_ctrl: scenario tasks plus a done-driven scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_bitcell_array_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    logic [3:0] mem [16];
    logic [3:0] rdata_model = 4'h0;
    logic [3:0] sb [$];

    bitcell_array_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    bitcell_array_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: every done pops one expected rdata.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected_done: got done with rdata=%h, required no done", bus.rdata);
            end else begin
                logic [3:0] exp;
                exp = sb.pop_front();
                if (bus.rdata !== exp) begin
                    failed++;
                    $display("FAIL sb_rdata: got %h, required %h", bus.rdata, exp);
                end
            end
        end
    end

    // Called at a negedge; leaves the caller at the negedge where done is high.
    task automatic do_access(input logic w, input logic [3:0] a, input logic [3:0] d);
        int n;
        bus.valid = 1'b1;
        bus.rw    = w;
        bus.addr  = a;
        bus.wdata = d;
        if (w) begin
            sb.push_back(rdata_model);
            mem[a] = d;
        end else begin
            rdata_model = mem[a];
            sb.push_back(rdata_model);
        end
        @(negedge clk);
        bus.valid = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.done !== 1'b1 || n != 3) begin
            failed++;
            $display("FAIL access_latency: rw=%0d addr=%h got done=%b after %0d cycles, required done after 3", w, a, bus.done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        tests++; if (bus.wl !== 16'h0000) begin failed++; $display("FAIL reset_wl: got %h, required 0000", bus.wl); end
        tests++; if (bus.we !== 1'b0)     begin failed++; $display("FAIL reset_we: got %b, required 0", bus.we); end
        tests++; if (bus.done !== 1'b0)   begin failed++; $display("FAIL reset_done: got %b, required 0", bus.done); end
        tests++; if (bus.busy !== 1'b0)   begin failed++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        tests++; if (bus.drop !== 1'b0)   begin failed++; $display("FAIL reset_drop: got %b, required 0", bus.drop); end
        tests++; if (bus.rdata !== 4'h0)  begin failed++; $display("FAIL reset_rdata: got %h, required 0", bus.rdata); end
        rst = 1'b0;
        rdata_model = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_write_timing();
        bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = 4'h3; bus.wdata = 4'hA;
        sb.push_back(rdata_model);
        mem[3] = 4'hA;
        @(negedge clk);   // DECODE
        bus.valid = 1'b0;
        tests++; if (bus.wl !== 16'h0008 || bus.we !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failed++; $display("FAIL wr_decode: got wl=%h we=%b busy=%b done=%b, required 0008 0 1 0", bus.wl, bus.we, bus.busy, bus.done);
        end
        @(negedge clk);   // ACCESS
        tests++; if (bus.wl !== 16'h0008 || bus.we !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failed++; $display("FAIL wr_access: got wl=%h we=%b busy=%b done=%b, required 0008 1 1 0", bus.wl, bus.we, bus.busy, bus.done);
        end
        @(negedge clk);   // DONE
        tests++; if (bus.wl !== 16'h0000 || bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            failed++; $display("FAIL wr_done: got wl=%h we=%b busy=%b done=%b, required 0000 0 0 1", bus.wl, bus.we, bus.busy, bus.done);
        end
        @(negedge clk);   // IDLE
        tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL wr_done_pulse: got %b, required 0", bus.done); end
    endtask

    task automatic test_read_timing();
        bus.valid = 1'b1; bus.rw = 1'b0; bus.addr = 4'h3; bus.wdata = 4'h0;
        rdata_model = mem[3];
        sb.push_back(rdata_model);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.valid = 1'b0;
            tests++; if (bus.we !== 1'b0) begin failed++; $display("FAIL rd_we_cycle%0d: got %b, required 0", k + 1, bus.we); end
        end
        tests++; if (bus.done !== 1'b1 || bus.rdata !== 4'hA) begin
            failed++; $display("FAIL rd_result: got done=%b rdata=%h, required 1 A", bus.done, bus.rdata);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        do_access(1'b1, 4'hF, 4'h5);
        do_access(1'b0, 4'hF, 4'h0);
        tests++; if (cyc - c0 != 6 || bus.rdata !== 4'h5) begin
            failed++; $display("FAIL b2b_raw: got %0d cycles rdata=%h, required 6 cycles rdata=5", cyc - c0, bus.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_drop();
        bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = 4'h7; bus.wdata = 4'h9;
        sb.push_back(rdata_model);
        mem[7] = 4'h9;
        @(negedge clk);   // DECODE: stray request
        bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = 4'h3; bus.wdata = 4'hF;
        @(negedge clk);   // ACCESS: stray request again
        tests++; if (bus.drop !== 1'b1 || bus.wl !== 16'h0080 || bus.we !== 1'b1) begin
            failed++; $display("FAIL drop_first: got drop=%b wl=%h we=%b, required 1 0080 1", bus.drop, bus.wl, bus.we);
        end
        @(negedge clk);   // DONE
        bus.valid = 1'b0;
        tests++; if (bus.drop !== 1'b1 || bus.done !== 1'b1) begin
            failed++; $display("FAIL drop_second: got drop=%b done=%b, required 1 1", bus.drop, bus.done);
        end
        @(negedge clk);
        tests++; if (bus.drop !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL drop_after: got drop=%b done=%b busy=%b, required 0 0 0", bus.drop, bus.done, bus.busy);
        end
        do_access(1'b0, 4'h7, 4'h0);
        do_access(1'b0, 4'h3, 4'h0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_access(1'b1, 4'h0, 4'h6);
        // Write that reset will abort: no scoreboard entry, model untouched.
        bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = 4'h0; bus.wdata = 4'hC;
        @(negedge clk);   // DECODE
        bus.valid = 1'b0;
        @(negedge clk);   // ACCESS
        tests++; if (bus.we !== 1'b1) begin failed++; $display("FAIL rstmid_we: got %b, required 1", bus.we); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.wl !== 16'h0000 || bus.we !== 1'b0 || bus.rdata !== 4'h0) begin
            failed++; $display("FAIL rstmid_state: got done=%b busy=%b wl=%h we=%b rdata=%h, required 0 0 0000 0 0",
                               bus.done, bus.busy, bus.wl, bus.we, bus.rdata);
        end
        rst = 1'b0;
        rdata_model = 4'h0;
        @(negedge clk);
        do_access(1'b0, 4'h0, 4'h0);
        tests++; if (bus.rdata !== 4'h6) begin failed++; $display("FAIL rstmid_keep: got %h, required 6", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            a = 4'(i);
            do_access(1'b1, a, 4'hF - a);
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            a = 4'(i);
            do_access(1'b0, a, 4'h0);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_timing();
        test_read_timing();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_sweep();
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL sb_leftover: got %0d outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bitcell_array_ctrl.md
# bitcell_array_ctrl

Downstream stage of the request FSM: consumes its registered `valid`/`rw` pair and executes one access on a small NAND-latch bitcell array. Each accepted request latches the address and write data, decodes a one-hot word line, performs the write or sense, and returns a one-cycle `done` pulse with read data. The block sits between the request FSM and the bitcell rows it instantiates. Requests that arrive while it is busy are reported, not queued.

## Interface
- `ADDR_W`, 4, address width; array depth is 2**ADDR_W words
- `DATA_W`, 4, bits per word
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid`  in  1  request strobe from the request FSM
- `rw`  in  1  request type: 1 = write, 0 = read; meaningful only with `valid`
- `addr`  in  ADDR_W  word address, sampled on accept
- `wdata`  in  DATA_W  write data, sampled on accept
- `wl`  out  2**ADDR_W  one-hot word line to the bitcell rows
- `we`  out  1  row write enable
- `rdata`  out  DATA_W  registered read data
- `done`  out  1  one-cycle completion pulse
- `busy`  out  1  request in flight; `valid` not accepted
- `drop`  out  1  one-cycle pulse: a request was rejected

## Operation
- States: IDLE, DECODE, ACCESS, DONE.
- Accept: `valid`=1 while in IDLE or DONE. Capture `addr`, `wdata`, `rw` into internal registers, then go to DECODE.
- DECODE → ACCESS unconditionally. `wl` is the one-hot decode of the captured address.
- ACCESS → DONE unconditionally. `wl` is held. `we`=1 only for writes. A write commits to the row on the edge that leaves ACCESS. A read samples the selected row into `rdata` on the same edge.
- DONE: `done`=1 and `wl`=0. If `valid`=1, accept and go to DECODE; otherwise go to IDLE.
- `busy`=1 in DECODE and ACCESS only.
- `valid`=1 while `busy`=1: the request is ignored and `drop` pulses on the next cycle. State and captured registers are unchanged.
- Writes leave `rdata` unchanged. `rdata` holds its value until the next completed read.
- Reset: state → IDLE; `wl`, `we`, `done`, `busy`, `drop`, `rdata` → 0. Array contents are not cleared; power-up contents are undefined.
- Reset mid-operation: reset wins over every transition. A write whose ACCESS-exit edge coincides with `rst`=1 is not committed.
- Only the addressed row ever changes. Every address from 0 to 2**ADDR_W−1 is valid, with no wrap.

## Timing
- Valid is sampled at edge k in IDLE. The block is in DECODE in cycle k+1, ACCESS in k+2 and DONE in k+3.
- In cycle k+3, `done`=1 and, for reads, `rdata` is already valid.
- Latency from accepting edge to `done` high: 3 cycles.
- Best-case throughput is one access per 3 cycles, achieved by presenting `valid` during DONE.
- `we` and `wl` are registered outputs with no combinational path from inputs.
- Read-after-write to the same address, back-to-back: the read returns the new data.

## Structure
- Shared package `bitcell_pkg`: state encoding constants (IDLE=2'd0, DECODE=2'd1, ACCESS=2'd2, DONE=2'd3) and default `ADDR_W`/`DATA_W`.
- Sub-module `bitcell_row`: one word of DATA_W NAND-latch bitcells.
  - Inputs: `wl`, `we`, `d`. Output: `q`.
  - Instantiated 2**ADDR_W times.
  - Read mux and decoder stay in this block.

## Test plan
- Reset, then write addr=4'h3 wdata=4'hA → `done` 3 cycles after accept; `wl`=16'h0008 during DECODE/ACCESS; `we`=1 in ACCESS only.
- Read addr=4'h3 after that write → `rdata`=4'hA in the `done` cycle; `we` stays 0.
- Write 4'h5 to 4'hF with a read of 4'hF presented in the DONE cycle → read accepted immediately and returns 4'h5, for 6 cycles total.
- `valid` pulsed in DECODE and again in ACCESS → two `drop` pulses; the original access completes unchanged.
- `rst` asserted on the ACCESS-exit edge of a write of 4'hC to addr 0 → no `done`; a later read of addr 0 returns the prior value.
- Write a unique value to every address 0..15, then read all back → each read matches and no other row is disturbed.
